// File: rtl/ship_pkg.sv
// Shared types, direction tables and velocity helpers for the player-ship engine.
package ship_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEER,
    ST_THRUST,
    ST_MOVE,
    ST_FIRE
  } ship_state_t;

  // Unit vectors scaled by 4; y grows downward, so DY is the negated sine.
  localparam logic signed [3:0] DIR_DX [16] = '{
    4'sd4, 4'sd4, 4'sd3, 4'sd2, 4'sd0, -4'sd2, -4'sd3, -4'sd4,
    -4'sd4, -4'sd4, -4'sd3, -4'sd2, 4'sd0, 4'sd2, 4'sd3, 4'sd4
  };
  localparam logic signed [3:0] DIR_DY [16] = '{
    4'sd0, -4'sd2, -4'sd3, -4'sd4, -4'sd4, -4'sd4, -4'sd3, -4'sd2,
    4'sd0, 4'sd2, 4'sd3, 4'sd4, 4'sd4, 4'sd4, 4'sd3, 4'sd2
  };

  function automatic logic signed [7:0] sat_vel(input logic signed [7:0] v,
                                                input logic signed [3:0] d,
                                                input logic sub,
                                                input int lim);
    logic signed [8:0] s;
    s = sub ? ({v[7], v} - {{5{d[3]}}, d}) : ({v[7], v} + {{5{d[3]}}, d});
    if (int'(s) > lim) return 8'(lim);
    else if (int'(s) < -lim) return 8'(-lim);
    else return s[7:0];
  endfunction

  function automatic logic signed [7:0] toward_zero(input logic signed [7:0] v);
    if (v > 0) return v - 8'sd1;
    else if (v < 0) return v + 8'sd1;
    else return v;
  endfunction

endpackage

// File: rtl/ship_control_if.sv
// Key inputs, frame strobe and ship/bullet outputs between keyboard, ship engine and draw path.
interface ship_control_if;
  logic       tick;
  logic       shoot;
  logic       forward;
  logic       backward;
  logic       right_rotate;
  logic       left_rotate;
  logic [3:0] heading;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic       fire;
  logic [7:0] bullet_x;
  logic [6:0] bullet_y;
  logic [3:0] bullet_heading;
  logic       update_done;

  modport master (
    output tick, shoot, forward, backward, right_rotate, left_rotate,
    input  heading, pos_x, pos_y, fire, bullet_x, bullet_y, bullet_heading, update_done
  );

  modport slave (
    input  tick, shoot, forward, backward, right_rotate, left_rotate,
    output heading, pos_x, pos_y, fire, bullet_x, bullet_y, bullet_heading, update_done
  );
endinterface

// File: rtl/ship_wrap.sv
// One position axis: 8.4 position plus signed velocity, wrapped once into [0, SPAN).
module ship_wrap #(
  parameter int SPAN = 2560
) (
  input  logic [11:0]       p,
  input  logic signed [7:0] v,
  output logic [11:0]       q
);
  localparam logic signed [13:0] SPAN_S = 14'(SPAN);

  logic signed [13:0] sum;

  always_comb begin
    sum = $signed({2'b00, p}) + $signed({{6{v[7]}}, v});
    if (sum < 0) q = 12'(sum + SPAN_S);
    else if (sum >= SPAN_S) q = 12'(sum - SPAN_S);
    else q = sum[11:0];
  end
endmodule

// File: rtl/ship_control.sv
// Per-frame ship state engine: heading, velocity, wrapped position and bullet requests.
// Build option: define SHIP_FRICTION_EN to decay velocity by 1 per frame when there is no thrust.
//
// state     | meaning
// ST_IDLE   | waiting for frame tick
// ST_STEER  | rotate-divider count and heading step
// ST_THRUST | velocity update with per-axis saturation
// ST_MOVE   | position update; fire decision registered for next cycle
// ST_FIRE   | fire/bullet/update_done visible, then back to idle
module ship_control
  import ship_pkg::*;
#(
  parameter int SCREEN_W      = SCREEN_W_DEF,
  parameter int SCREEN_H      = SCREEN_H_DEF,
  parameter int MAX_SPEED     = 32,
  parameter int ROT_DIV       = 4,
  parameter int FIRE_COOLDOWN = 8
) (
  input  logic           clk,
  input  logic           reset,
  ship_control_if.slave  bus
);
  localparam logic [11:0] PX_RST = 12'((SCREEN_W / 2) * 16);
  localparam logic [11:0] PY_RST = 12'((SCREEN_H / 2) * 16);

  ship_state_t       state;
  logic [3:0]        heading;
  logic [11:0]       px, py, px_next, py_next;
  logic signed [7:0] vx, vy, vx_next, vy_next;
  logic [7:0]        rot_cnt;
  logic [7:0]        cooldown;
  logic              fire_req, shoot_q;
  logic              fire, update_done;
  logic [7:0]        bullet_x;
  logic [6:0]        bullet_y;
  logic [3:0]        bullet_heading;
  logic              shoot_rise, fire_go;

  assign shoot_rise = bus.shoot & ~shoot_q;
  // An edge landing on the MOVE->FIRE clock still counts for this frame.
  assign fire_go    = (fire_req | shoot_rise) && (cooldown == 8'd0);

  always_comb begin
    vx_next = vx;
    vy_next = vy;
    if (bus.forward && !bus.backward) begin
      vx_next = sat_vel(vx, DIR_DX[heading], 1'b0, MAX_SPEED);
      vy_next = sat_vel(vy, DIR_DY[heading], 1'b0, MAX_SPEED);
    end else if (bus.backward && !bus.forward) begin
      vx_next = sat_vel(vx, DIR_DX[heading], 1'b1, MAX_SPEED);
      vy_next = sat_vel(vy, DIR_DY[heading], 1'b1, MAX_SPEED);
    end
`ifdef SHIP_FRICTION_EN
    else begin
      vx_next = toward_zero(vx);
      vy_next = toward_zero(vy);
    end
`endif
  end

  ship_wrap #(.SPAN(SCREEN_W * 16)) u_wrap_x (.p(px), .v(vx), .q(px_next));
  ship_wrap #(.SPAN(SCREEN_H * 16)) u_wrap_y (.p(py), .v(vy), .q(py_next));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      heading        <= 4'd0;
      px             <= PX_RST;
      py             <= PY_RST;
      vx             <= 8'sd0;
      vy             <= 8'sd0;
      rot_cnt        <= 8'd0;
      cooldown       <= 8'd0;
      fire_req       <= 1'b0;
      shoot_q        <= 1'b0;
      fire           <= 1'b0;
      update_done    <= 1'b0;
      bullet_x       <= 8'd0;
      bullet_y       <= 7'd0;
      bullet_heading <= 4'd0;
    end else begin
      shoot_q     <= bus.shoot;
      fire        <= 1'b0;
      update_done <= 1'b0;
      if (shoot_rise) fire_req <= 1'b1;
      case (state)
        ST_IDLE: if (bus.tick) state <= ST_STEER;
        ST_STEER: begin
          state <= ST_THRUST;
          if (bus.left_rotate ^ bus.right_rotate) begin
            if (rot_cnt + 8'd1 == 8'(ROT_DIV)) begin
              rot_cnt <= 8'd0;
              heading <= bus.left_rotate ? heading + 4'd1 : heading - 4'd1;
            end else begin
              rot_cnt <= rot_cnt + 8'd1;
            end
          end else begin
            rot_cnt <= 8'd0;
          end
        end
        ST_THRUST: begin
          state <= ST_MOVE;
          vx    <= vx_next;
          vy    <= vy_next;
        end
        ST_MOVE: begin
          state       <= ST_FIRE;
          px          <= px_next;
          py          <= py_next;
          update_done <= 1'b1;
          fire_req    <= 1'b0;
          if (fire_go) begin
            fire           <= 1'b1;
            bullet_x       <= px_next[11:4];
            bullet_y       <= py_next[10:4];
            bullet_heading <= heading;
            cooldown       <= 8'(FIRE_COOLDOWN);
          end else if (cooldown != 8'd0) begin
            cooldown <= cooldown - 8'd1;
          end
        end
        ST_FIRE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.heading        = heading;
  assign bus.pos_x          = px[11:4];
  assign bus.pos_y          = py[10:4];
  assign bus.fire           = fire;
  assign bus.update_done    = update_done;
  assign bus.bullet_x       = bullet_x;
  assign bus.bullet_y       = bullet_y;
  assign bus.bullet_heading = bullet_heading;
endmodule

// File: tb/tb_ship_control.sv
// Randomized and directed frames checked against a trig-based behavioural ship model.
module tb_ship_control;
  localparam int SW = 160, SH = 120, MAXS = 32, RDIV = 4, COOL = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0, bad = 0;

  ship_control_if bus ();

  ship_control #(
    .SCREEN_W(SW), .SCREEN_H(SH), .MAX_SPEED(MAXS), .ROT_DIV(RDIV), .FIRE_COOLDOWN(COOL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int m_head, m_vx, m_vy, m_px, m_py, m_rc, m_cd;
  bit m_pend, shoot_prev;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int rnd4(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else return -$rtoi(-r + 0.5);
  endfunction

  function automatic int dir_dx(input int h);
    return rnd4(4.0 * $cos(h * 3.14159265358979 / 8.0));
  endfunction

  function automatic int dir_dy(input int h);
    return -rnd4(4.0 * $sin(h * 3.14159265358979 / 8.0));
  endfunction

  function automatic int clampv(input int v);
    if (v > MAXS) return MAXS;
    if (v < -MAXS) return -MAXS;
    return v;
  endfunction

  function automatic int wrap(input int p, input int span);
    if (p < 0) return p + span;
    if (p >= span) return p - span;
    return p;
  endfunction

  function automatic int decay(input int v);
    if (v > 0) return v - 1;
    if (v < 0) return v + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_head = 0; m_vx = 0; m_vy = 0; m_rc = 0; m_cd = 0; m_pend = 0;
    m_px = (SW / 2) * 16; m_py = (SH / 2) * 16;
  endtask

  task automatic set_shoot(input bit v);
    if (v && !shoot_prev) m_pend = 1;
    shoot_prev = v;
    bus.shoot = v;
  endtask

  task automatic set_keys(input bit f, input bit b, input bit l, input bit r);
    bus.forward = f; bus.backward = b; bus.left_rotate = l; bus.right_rotate = r;
  endtask

  task automatic model_steer();
    if (bus.left_rotate != bus.right_rotate) begin
      m_rc++;
      if (m_rc == RDIV) begin
        m_rc = 0;
        m_head = bus.left_rotate ? (m_head + 1) % 16 : (m_head + 15) % 16;
      end
    end else m_rc = 0;
  endtask

  task automatic model_rest(output bit efire);
    if (bus.forward && !bus.backward) begin
      m_vx = clampv(m_vx + dir_dx(m_head));
      m_vy = clampv(m_vy + dir_dy(m_head));
    end else if (bus.backward && !bus.forward) begin
      m_vx = clampv(m_vx - dir_dx(m_head));
      m_vy = clampv(m_vy - dir_dy(m_head));
    end
`ifdef SHIP_FRICTION_EN
    else begin
      m_vx = decay(m_vx);
      m_vy = decay(m_vy);
    end
`endif
    m_px = wrap(m_px + m_vx, SW * 16);
    m_py = wrap(m_py + m_vy, SH * 16);
    efire = m_pend && (m_cd == 0);
    if (efire) m_cd = COOL;
    else if (m_cd > 0) m_cd--;
    m_pend = 0;
  endtask

  // shoot_at: 3 raises shoot in the MOVE cycle, 4 in the FIRE cycle, otherwise no change.
  task automatic frame(input int shoot_at, input bit extra_tick);
    bit efire;
    int pulses;
    @(posedge clk); #1 bus.tick = 1'b1;
    @(posedge clk); #1 bus.tick = 1'b0;
    @(posedge clk); #1;
    model_steer();
    chk("heading", bus.heading, m_head);
    if (extra_tick) bus.tick = 1'b1;
    @(posedge clk); #1 bus.tick = 1'b0;
    chk("early_done", bus.update_done, 0);
    if (shoot_at == 3) set_shoot(1);
    @(posedge clk); #1;
    model_rest(efire);
    chk("update_done", bus.update_done, 1);
    chk("fire", bus.fire, efire);
    chk("pos_x", bus.pos_x, m_px / 16);
    chk("pos_y", bus.pos_y, m_py / 16);
    if (efire) begin
      chk("bullet_x", bus.bullet_x, m_px / 16);
      chk("bullet_y", bus.bullet_y, m_py / 16);
      chk("bullet_heading", bus.bullet_heading, m_head);
    end
    if (shoot_at == 4) set_shoot(1);
    @(posedge clk); #1;
    chk("done_pulse_end", bus.update_done + bus.fire, 0);
    if (extra_tick) begin
      pulses = 0;
      repeat (6) begin
        @(posedge clk); #1;
        pulses += bus.update_done;
      end
      chk("dropped_tick", pulses, 0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_x"}, bus.pos_x, SW / 2);
    chk({tag, "_y"}, bus.pos_y, SH / 2);
    chk({tag, "_hd"}, bus.heading, 0);
    chk({tag, "_fire"}, bus.fire, 0);
    chk({tag, "_done"}, bus.update_done, 0);
    chk({tag, "_bul"}, bus.bullet_x + bus.bullet_y + bus.bullet_heading, 0);
  endtask

  initial begin
    int fires;
    bus.tick = 1'b0;
    bus.shoot = 1'b0;
    shoot_prev = 0;
    set_keys(0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("rst");
    reset = 1'b1;

    frame(0, 0);
    set_keys(0, 0, 1, 0);
    repeat (8) frame(0, 0);
    set_keys(0, 0, 1, 1);
    repeat (3) frame(0, 0);
    set_keys(0, 0, 0, 1);
    repeat (5) frame(0, 0);

    // Fire / cooldown sequences
    set_keys(0, 0, 0, 0);
    set_shoot(1); frame(0, 0); set_shoot(0);
    repeat (2) frame(0, 0);
    set_shoot(1); frame(0, 0); set_shoot(0);
    repeat (8) frame(0, 0);
    set_shoot(1); frame(0, 0);
    repeat (20) frame(0, 0);
    set_shoot(0);
    repeat (10) frame(0, 0);
    frame(3, 0);
    set_shoot(0);
    repeat (10) frame(0, 0);
    frame(4, 0);
    set_shoot(0);
    repeat (9) frame(0, 0);

    // Saturated forward flight across the x edge, then steer to heading 4 and cross y
    set_keys(0, 0, 1, 0);
    for (int i = 0; i < 64 && m_head != 0; i++) frame(0, 0);
    set_keys(1, 0, 0, 0);
    repeat (70) frame(0, 0);
    set_keys(0, 0, 1, 0);
    for (int i = 0; i < 64 && m_head != 4; i++) frame(0, 0);
    set_keys(1, 0, 0, 0);
    repeat (80) frame(0, 0);
    set_keys(0, 1, 0, 0);
    repeat (20) frame(0, 0);

    set_keys(0, 0, 0, 0);
    frame(0, 1);

    for (int i = 0; i < 200; i++) begin
      set_keys($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      set_shoot($urandom_range(0, 2) == 0);
      frame(($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 4)) : 0, $urandom_range(0, 15) == 0);
    end

    // Reset in the middle of a frame with a shot pending
    set_keys(1, 0, 1, 0);
    set_shoot(0);
    frame(0, 0);
    set_shoot(1);
    @(posedge clk); #1 bus.tick = 1'b1;
    @(posedge clk); #1 bus.tick = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    bus.shoot = 1'b0;
    shoot_prev = 0;
    model_reset();
    #1 chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    fires = 0;
    repeat (8) begin
      @(posedge clk); #1;
      fires += bus.fire + bus.update_done;
    end
    chk("midrst_no_fire", fires, 0);
    set_keys(0, 0, 0, 0);
    repeat (3) frame(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
